// File: rtl/sprite_pkg.sv
// sprite_pkg
//   Shared definitions for the sprite drawing path: the layout of one
//   sprite-table entry, default screen dimensions and the drawer FSM states.
//   Used by sprite_drawer and sprite_pixel_calc (and by the loader / VGA top).
package sprite_pkg;

  localparam int ENTRY_W      = 16;
  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  // One table entry as stored in the sprite RAM, MSB first.
  typedef struct packed {
    logic [5:0] x_off;
    logic [5:0] y_off;
    logic [2:0] colour;
    logic       more;     // 0 marks the last entry of the table
  } sprite_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_EMIT  = 2'd2,
    ST_ISSUE = 2'd3
  } draw_state_t;

endpackage

// File: rtl/sprite_pixel_calc.sv
// sprite_pixel_calc
//   Combinational: turns one sprite-table entry plus the latched origin into
//   a screen pixel, and decides whether that pixel may be plotted.
// Ports
//   entry    in  16  raw table entry from the sprite RAM
//   base_x   in  8   sprite origin x
//   base_y   in  7   sprite origin y
//   x        out 8   pixel x (low bits of the unwrapped sum)
//   y        out 7   pixel y (low bits of the unwrapped sum)
//   colour   out 3   pixel colour
//   more     out 1   entry is not the last one
//   plot_ok  out 1   pixel is on screen and not transparent
module sprite_pixel_calc
  import sprite_pkg::*;
#(
  parameter int         SCREEN_W   = SCREEN_W_DEF,
  parameter int         SCREEN_H   = SCREEN_H_DEF,
  parameter bit         TRANSP_EN  = 1'b1,
  parameter logic [2:0] TRANSP_COL = 3'b000
) (
  input  logic [ENTRY_W-1:0] entry,
  input  logic [7:0]         base_x,
  input  logic [6:0]         base_y,
  output logic [7:0]         x,
  output logic [6:0]         y,
  output logic [2:0]         colour,
  output logic               more,
  output logic               plot_ok
);

  sprite_entry_t e;
  logic [8:0]    x_full;
  logic [7:0]    y_full;
  logic          on_screen;
  logic          transparent;

  assign e = sprite_entry_t'(entry);

  // One extra bit on each sum so an origin near the edge clips instead of
  // wrapping back onto the left/top of the screen.
  assign x_full = {1'b0, base_x} + {3'b000, e.x_off};
  assign y_full = {1'b0, base_y} + {2'b00, e.y_off};

  assign on_screen   = (x_full < 9'(SCREEN_W)) && (y_full < 8'(SCREEN_H));
  assign transparent = TRANSP_EN && (e.colour == TRANSP_COL);

  assign x       = x_full[7:0];
  assign y       = y_full[6:0];
  assign colour  = e.colour;
  assign more    = e.more;
  assign plot_ok = on_screen && !transparent;

endmodule

// File: rtl/sprite_drawer.sv
// sprite_drawer
//   Walks a sprite table in the sprite RAM from address 0 and issues one
//   plot strobe per visible entry to the VGA adapter.
// Ports
//   clk         in   1       system clock
//   resetn      in   1       asynchronous active-low reset
//   start       in   1       draw request, honoured only while idle
//   base_x      in   8       origin x, latched on an accepted start
//   base_y      in   7       origin y, latched on an accepted start
//   ram_addr    out  ADDR_W  sprite RAM read address (registered)
//   ram_q       in   16      sprite RAM read data
//   x_out       out  8       pixel x (registered)
//   y_out       out  7       pixel y (registered)
//   colour_out  out  3       pixel colour (registered)
//   plot        out  1       one-cycle write strobe
//   busy        out  1       draw in progress
//   done        out  1       one-cycle pulse after the last entry
module sprite_drawer
  import sprite_pkg::*;
#(
  parameter int         ADDR_W      = 10,
  parameter int         RAM_LATENCY = 2,
  parameter int         SCREEN_W    = SCREEN_W_DEF,
  parameter int         SCREEN_H    = SCREEN_H_DEF,
  parameter bit         TRANSP_EN   = 1'b1,
  parameter logic [2:0] TRANSP_COL  = 3'b000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [7:0]        base_x,
  input  logic [6:0]        base_y,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [ENTRY_W-1:0] ram_q,
  output logic [7:0]        x_out,
  output logic [6:0]        y_out,
  output logic [2:0]        colour_out,
  output logic              plot,
  output logic              busy,
  output logic              done
);

  localparam int                CNT_W    = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RAM_LATENCY - 1);
  localparam logic [ADDR_W-1:0] ADDR_TOP = '1;

  draw_state_t       state, state_n;
  logic [CNT_W-1:0]  lat_cnt, lat_cnt_n;
  logic [ADDR_W-1:0] ram_addr_n;
  logic [7:0]        org_x, org_x_n;
  logic [6:0]        org_y, org_y_n;
  logic [7:0]        x_out_n;
  logic [6:0]        y_out_n;
  logic [2:0]        colour_out_n;
  logic              plot_n, busy_n, done_n;
  logic              more_q, more_n;

  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic [2:0] pix_colour;
  logic       pix_more;
  logic       pix_plot_ok;

  sprite_pixel_calc #(
    .SCREEN_W   (SCREEN_W),
    .SCREEN_H   (SCREEN_H),
    .TRANSP_EN  (TRANSP_EN),
    .TRANSP_COL (TRANSP_COL)
  ) u_pixel_calc (
    .entry   (ram_q),
    .base_x  (org_x),
    .base_y  (org_y),
    .x       (pix_x),
    .y       (pix_y),
    .colour  (pix_colour),
    .more    (pix_more),
    .plot_ok (pix_plot_ok)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      lat_cnt    <= '0;
      ram_addr   <= '0;
      org_x      <= '0;
      org_y      <= '0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      more_q     <= 1'b0;
    end else begin
      state      <= state_n;
      lat_cnt    <= lat_cnt_n;
      ram_addr   <= ram_addr_n;
      org_x      <= org_x_n;
      org_y      <= org_y_n;
      x_out      <= x_out_n;
      y_out      <= y_out_n;
      colour_out <= colour_out_n;
      plot       <= plot_n;
      busy       <= busy_n;
      done       <= done_n;
      more_q     <= more_n;
    end
  end

  always_comb begin
    state_n      = state;
    lat_cnt_n    = lat_cnt;
    ram_addr_n   = ram_addr;
    org_x_n      = org_x;
    org_y_n      = org_y;
    x_out_n      = x_out;
    y_out_n      = y_out;
    colour_out_n = colour_out;
    plot_n       = 1'b0;
    busy_n       = busy;
    done_n       = 1'b0;
    more_n       = more_q;

    case (state)
      ST_IDLE: begin
        if (start) begin
          org_x_n    = base_x;
          org_y_n    = base_y;
          ram_addr_n = '0;
          lat_cnt_n  = '0;
          busy_n     = 1'b1;
          state_n    = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // lat_cnt counts edges since ram_addr last changed; on the
        // RAM_LATENCY-th edge ram_q belongs to the current address.
        if (lat_cnt == CNT_LAST) begin
          x_out_n      = pix_x;
          y_out_n      = pix_y;
          colour_out_n = pix_colour;
          plot_n       = pix_plot_ok;
          more_n       = pix_more;
          state_n      = ST_EMIT;
        end else begin
          lat_cnt_n = lat_cnt + 1'b1;
        end
      end

      ST_EMIT: begin
        // The next read is issued on this same edge, so ST_ISSUE is never
        // occupied as a separate cycle. The top address always ends the table.
        if (more_q && (ram_addr != ADDR_TOP)) begin
          ram_addr_n = ram_addr + 1'b1;
          lat_cnt_n  = '0;
          state_n    = ST_WAIT;
        end else begin
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end

      default: begin
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sprite_drawer.sv
// tb_sprite_drawer
//   Two drawer instances: A (ADDR_W=10, latency 2, transparency on) and
//   B (ADDR_W=4, latency 3, transparency off), each fed by a RAM model with
//   the matching read latency. Expected traces come from a cycle-indexed
//   model of the draw: entry k is plotted at cycle L + k*(L+1).
module tb_sprite_drawer;

  localparam int LA  = 2;
  localparam int AWA = 10;
  localparam int LB  = 3;
  localparam int AWB = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic           start_a, start_b;
  logic [7:0]     bx_a, bx_b;
  logic [6:0]     by_a, by_b;
  logic [AWA-1:0] addr_a;
  logic [AWB-1:0] addr_b;
  logic [15:0]    q_a, q_b;
  logic [7:0]     x_a, x_b;
  logic [6:0]     y_a, y_b;
  logic [2:0]     c_a, c_b;
  logic           plot_a, plot_b, busy_a, busy_b, done_a, done_b;

  logic [15:0]    mem_a [0:(1<<AWA)-1];
  logic [15:0]    mem_b [0:(1<<AWB)-1];
  logic [AWA-1:0] dly_a;
  logic [AWB-1:0] dly_b0, dly_b1;

  // Read port: data for an address appears L-1 edges after it is presented
  // and is sampled by the drawer on the L-th edge.
  always @(posedge clk) begin
    dly_a  <= addr_a;
    dly_b0 <= addr_b;
    dly_b1 <= dly_b0;
  end
  assign q_a = mem_a[dly_a];
  assign q_b = mem_b[dly_b1];

  sprite_drawer #(.ADDR_W(AWA), .RAM_LATENCY(LA), .TRANSP_EN(1'b1)) dut_a (
    .clk(clk), .resetn(resetn), .start(start_a), .base_x(bx_a), .base_y(by_a),
    .ram_addr(addr_a), .ram_q(q_a), .x_out(x_a), .y_out(y_a), .colour_out(c_a),
    .plot(plot_a), .busy(busy_a), .done(done_a));

  sprite_drawer #(.ADDR_W(AWB), .RAM_LATENCY(LB), .TRANSP_EN(1'b0)) dut_b (
    .clk(clk), .resetn(resetn), .start(start_b), .base_x(bx_b), .base_y(by_b),
    .ram_addr(addr_b), .ram_q(q_b), .x_out(x_b), .y_out(y_b), .colour_out(c_b),
    .plot(plot_b), .busy(busy_b), .done(done_b));

  int errors = 0;
  int checks = 0;

  function automatic logic [15:0] mk(input int xo, input int yo, input int col, input int more);
    return {6'(xo), 6'(yo), 3'(col), 1'(more)};
  endfunction

  function automatic logic [15:0] rd(input int inst, input int i);
    if (inst == 0) return mem_a[i];
    return mem_b[i];
  endfunction

  function automatic bit pix_ok(input int inst, input int bx, input int by, input logic [15:0] e);
    int x;
    int y;
    x = bx + int'(e[15:10]);
    y = by + int'(e[9:4]);
    return (x < 160) && (y < 120) && !((inst == 0) && (e[3:1] == 3'b000));
  endfunction

  task automatic drive(input int inst, input logic s, input int bx, input int by);
    if (inst == 0) begin start_a = s; bx_a = 8'(bx); by_a = 7'(by); end
    else begin start_b = s; bx_b = 8'(bx); by_b = 7'(by); end
  endtask

  task automatic drive_start(input int inst, input logic s);
    if (inst == 0) start_a = s;
    else start_b = s;
  endtask

  task automatic sample(input int inst, output logic [9:0] a, output logic [7:0] x,
                        output logic [6:0] y, output logic [2:0] c,
                        output logic p, output logic b, output logic d);
    if (inst == 0) begin
      a = addr_a; x = x_a; y = y_a; c = c_a; p = plot_a; b = busy_a; d = done_a;
    end else begin
      a = {6'b0, addr_b}; x = x_b; y = y_b; c = c_b; p = plot_b; b = busy_b; d = done_b;
    end
  endtask

  // Runs one draw from its start edge (cycle 0) and compares every cycle
  // against the model. mid_pulse: cycle at which a stray start is raised
  // (-1 for none). hold_end: raise start over the last plot and done cycles
  // with origin (nbx,nby), leaving the next draw already started.
  task automatic run_draw(input int inst, input string name, input int bx, input int by,
                          input bit pre_started, input int mid_pulse, input bit hold_end,
                          input int nbx, input int nby);
    int lat, top, n, d, last_c, k, q;
    logic [15:0] e;
    logic [9:0] a_o, a_e;
    logic [7:0] x_o, x_e;
    logic [6:0] y_o, y_e;
    logic [2:0] c_o, c_e;
    logic p_o, b_o, d_o, p_e, b_e, d_e;
    lat = (inst == 0) ? LA : LB;
    top = (inst == 0) ? (1 << AWA) - 1 : (1 << AWB) - 1;
    n = 0;
    for (int i = 0; i <= top; i++) begin
      e = rd(inst, i);
      n++;
      if (e[0] == 1'b0) break;
    end
    d = lat + (n - 1) * (lat + 1) + 1;
    last_c = hold_end ? d : d + 2;
    if (!pre_started) @(negedge clk);
    drive(inst, 1'b1, bx, by);
    @(posedge clk);
    for (int c = 0; c <= last_c; c++) begin
      @(negedge clk);
      sample(inst, a_o, x_o, y_o, c_o, p_o, b_o, d_o);
      k = (c < lat) ? 0 : (c - lat) / (lat + 1);
      if (k > n - 1) k = n - 1;
      e = rd(inst, k);
      b_e = (c < d);
      d_e = (c == d);
      p_e = (c >= lat) && ((c - lat) % (lat + 1) == 0) && ((c - lat) / (lat + 1) < n)
            && pix_ok(inst, bx, by, e);
      q = c / (lat + 1);
      if (q > n - 1) q = n - 1;
      a_e = 10'(q);
      x_e = 8'(bx + int'(e[15:10]));
      y_e = 7'(by + int'(e[9:4]));
      c_e = e[3:1];
      checks += 4;
      if (b_o !== b_e) begin errors++; $display("FAIL %s busy c=%0d got %b want %b", name, c, b_o, b_e); end
      if (d_o !== d_e) begin errors++; $display("FAIL %s done c=%0d got %b want %b", name, c, d_o, d_e); end
      if (p_o !== p_e) begin errors++; $display("FAIL %s plot c=%0d got %b want %b", name, c, p_o, p_e); end
      if (a_o !== a_e) begin errors++; $display("FAIL %s ram_addr c=%0d got %0d want %0d", name, c, a_o, a_e); end
      if (c >= lat) begin
        checks += 1;
        if ({x_o, y_o, c_o} !== {x_e, y_e, c_e}) begin
          errors++;
          $display("FAIL %s pixel c=%0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                   name, c, x_o, y_o, c_o, x_e, y_e, c_e);
        end
      end
      if (hold_end && c >= d - 1) drive(inst, 1'b1, nbx, nby);
      else if (c == mid_pulse) drive(inst, 1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)));
      else drive_start(inst, 1'b0);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    drive(0, 1'b0, 0, 0);
    drive(1, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    checks += 2;
    if ({addr_a, x_a, y_a, c_a, plot_a, busy_a, done_a} !== '0) begin
      errors++; $display("FAIL reset_a outputs got %h want 0", {addr_a, x_a, y_a, c_a, plot_a, busy_a, done_a});
    end
    if ({addr_b, x_b, y_b, c_b, plot_b, busy_b, done_b} !== '0) begin
      errors++; $display("FAIL reset_b outputs got %h want 0", {addr_b, x_b, y_b, c_b, plot_b, busy_b, done_b});
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    mem_a[0] = mk(1, 2, 5, 1);
    mem_a[1] = mk(7, 3, 2, 1);
    mem_a[2] = mk(40, 30, 7, 0);
    run_draw(0, "basic", 10, 20, 1'b0, -1, 1'b0, 0, 0);
    checks += 1;
    if ({x_a, y_a, c_a} !== {8'd50, 7'd50, 3'd7}) begin
      errors++; $display("FAIL basic_last_pixel got (%0d,%0d,%0d) want (50,50,7)", x_a, y_a, c_a);
    end
  endtask

  task automatic test_clip;
    mem_a[0] = mk(5, 0, 3, 1);    // x = 163, off screen
    mem_a[1] = mk(0, 30, 4, 1);   // y = 130, off screen
    mem_a[2] = mk(1, 2, 6, 0);    // x = 159, y = 102, visible
    run_draw(0, "clip", 158, 100, 1'b0, -1, 1'b0, 0, 0);
    checks += 1;
    if (x_a !== 8'd159) begin errors++; $display("FAIL clip_x got %0d want 159", x_a); end
  endtask

  task automatic test_transparency;
    mem_a[0] = mk(3, 4, 0, 1);
    mem_a[1] = mk(1, 1, 6, 0);
    mem_b[0] = mk(3, 4, 0, 1);
    mem_b[1] = mk(1, 1, 6, 0);
    run_draw(0, "transp_on", 20, 20, 1'b0, -1, 1'b0, 0, 0);
    run_draw(1, "transp_off", 20, 20, 1'b0, -1, 1'b0, 0, 0);
  endtask

  task automatic test_start_rearm;
    mem_a[0] = mk(2, 2, 1, 1);
    mem_a[1] = mk(4, 5, 2, 1);
    mem_a[2] = mk(9, 9, 3, 0);
    run_draw(0, "ignore_mid", 30, 40, 1'b0, 3, 1'b1, 60, 70);
    run_draw(0, "rearm", 60, 70, 1'b1, -1, 1'b0, 0, 0);
  endtask

  task automatic test_addr_stop;
    for (int i = 0; i < 16; i++) mem_b[i] = mk(i, 15 - i, (i % 7) + 1, 1);
    run_draw(1, "addr_stop", 100, 50, 1'b0, -1, 1'b0, 0, 0);
    checks += 1;
    if (addr_b !== 4'd15) begin errors++; $display("FAIL addr_stop_final got %0d want 15", addr_b); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 4; i++) mem_a[i] = mk(i + 1, i + 2, 5, (i < 3) ? 1 : 0);
    @(negedge clk);
    drive(0, 1'b1, 12, 13);
    @(posedge clk);
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      drive_start(0, 1'b0);
    end
    checks += 1;
    if (addr_a !== 10'd2) begin errors++; $display("FAIL rst_mid_pre addr got %0d want 2", addr_a); end
    #1 resetn = 1'b0;
    #1;
    checks += 1;
    if ({addr_a, x_a, y_a, c_a, plot_a, busy_a, done_a} !== '0) begin
      errors++; $display("FAIL rst_mid outputs got %h want 0", {addr_a, x_a, y_a, c_a, plot_a, busy_a, done_a});
    end
    @(negedge clk);
    resetn = 1'b1;
    run_draw(0, "after_rst", 33, 44, 1'b0, -1, 1'b0, 0, 0);
  endtask

  task automatic test_random;
    int len, inst, top, bx, by, mp;
    for (int t = 0; t < 10; t++) begin
      inst = t % 2;
      top = (inst == 0) ? 24 : 16;
      len = int'($urandom_range(1, top));
      for (int i = 0; i < len; i++) begin
        if (inst == 0) mem_a[i] = mk(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                                     int'($urandom_range(0, 7)), (i < len - 1) ? 1 : 0);
        else mem_b[i] = mk(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                           int'($urandom_range(0, 7)), (i < len - 1) ? 1 : 0);
      end
      bx = int'($urandom_range(0, 170));
      by = int'($urandom_range(0, 127));
      mp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 2)) : -1;
      run_draw(inst, "random", bx, by, 1'b0, mp, 1'b0, 0, 0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AWA); i++) mem_a[i] = 16'($urandom);
    for (int i = 0; i < (1 << AWB); i++) mem_b[i] = 16'($urandom);
    test_reset();
    test_basic();
    test_clip();
    test_transparency();
    test_start_rearm();
    test_addr_stop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
